// File: rtl/wishbone_fifo_device.sv
// Wishbone classic device wrapping a FIFO: writes push, reads pop.
// Full/empty terminate with rty_o or err_o. Responses are registered, with optional wait states.
module wishbone_fifo_device #(
  parameter int unsigned DAT_WIDTH   = 8,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned FULL_IS_ERR = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cyc_i,
  input  logic                   stb_i,
  input  logic                   we_i,
  input  logic [DAT_WIDTH-1:0]   dat_i,
  output logic                   ack_o,
  output logic                   err_o,
  output logic                   rty_o,
  output logic [DAT_WIDTH-1:0]   dat_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam logic [LW-1:0] LevelFull = LW'(DEPTH);
  localparam logic [3:0] CntInit = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
  localparam bit UseErr = (FULL_IS_ERR != 0);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e               r_state, w_state_next;
  logic [3:0]           r_cnt, w_cnt_next;
  logic                 r_we, w_we_next;
  logic                 r_ack, r_err, r_rty;
  logic                 w_ack_next, w_err_next, w_rty_next;
  logic [DAT_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]        r_level;
  logic                 w_req, w_enter, w_ok, w_full, w_empty, w_push, w_pop;

  assign w_req   = cyc_i & stb_i;
  assign w_full  = (r_level == LevelFull);
  assign w_empty = (r_level == '0);
  // r_ack is only ever high during the single RESP cycle.
  assign w_push  = r_ack & r_we;
  assign w_pop   = r_ack & ~r_we;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_we_next    = r_we;
    w_enter      = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_req) begin
          w_we_next = we_i;
          if (WAIT_STATES == 0) begin
            w_enter = 1'b1;
          end else begin
            w_state_next = StWait;
            w_cnt_next   = CntInit;
          end
        end
      end
      StWait: begin
        if (!w_req) begin
          w_state_next = StIdle;
        end else if (r_cnt == 4'd0) begin
          w_enter = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      StResp:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
    if (w_enter) begin
      w_state_next = StResp;
    end
    // Termination is decided from the registered level as RESP is entered.
    w_ok       = w_we_next ? ~w_full : ~w_empty;
    w_ack_next = w_enter & w_ok;
    w_err_next = w_enter & ~w_ok & UseErr;
    w_rty_next = w_enter & ~w_ok & ~UseErr;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= StIdle;
      r_cnt    <= 4'd0;
      r_we     <= 1'b0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_rty    <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_we    <= w_we_next;
      r_ack   <= w_ack_next;
      r_err   <= w_err_next;
      r_rty   <= w_rty_next;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
        r_level  <= r_level + LW'(1);
      end else if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
        r_level  <= r_level - LW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && w_push) begin
      r_mem[r_wr_ptr] <= dat_i;
    end
  end

  assign ack_o   = r_ack;
  assign err_o   = r_err;
  assign rty_o   = r_rty;
  assign dat_o   = w_pop ? r_mem[r_rd_ptr] : '0;
  assign level_o = r_level;
  assign full_o  = w_full;
  assign empty_o = w_empty;

endmodule

// File: tb/tb_wishbone_fifo_device.sv
// Scoreboard bench: two DEPTH=4 devices (WAIT_STATES=2/rty and WAIT_STATES=3/err), driven in turn.
module tb_wishbone_fifo_device;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = 3;
  localparam logic [1:0] KAck = 2'd0, KErr = 2'd1, KRty = 2'd2;

  typedef struct packed {
    logic [1:0]    kind;
    logic [DW-1:0] data;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst   [2];
  logic          cyc   [2];
  logic          stb   [2];
  logic          we    [2];
  logic [DW-1:0] dat_w [2];
  logic          ack   [2];
  logic          err   [2];
  logic          rty   [2];
  logic [DW-1:0] dat_r [2];
  logic [LW-1:0] lvl   [2];
  logic          full  [2];
  logic          empty [2];

  int            checks   = 0;
  int            failures = 0;
  bit            mon_en   = 1'b0;
  rsp_t          q0[$];
  rsp_t          q1[$];
  logic [2:0]    prev_rsp [2];
  logic [LW-1:0] last_lvl [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    wishbone_fifo_device #(
      .DAT_WIDTH  (DW),
      .DEPTH      (DEPTH),
      .WAIT_STATES((g == 0) ? 2 : 3),
      .FULL_IS_ERR(g)
    ) u_dut (
      .clk_i  (clk),
      .rst_i  (rst[g]),
      .cyc_i  (cyc[g]),
      .stb_i  (stb[g]),
      .we_i   (we[g]),
      .dat_i  (dat_w[g]),
      .ack_o  (ack[g]),
      .err_o  (err[g]),
      .rty_o  (rty[g]),
      .dat_o  (dat_r[g]),
      .level_o(lvl[g]),
      .full_o (full[g]),
      .empty_o(empty[g])
    );
  end

  task automatic chk(input string name, input int s, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d actual=%0h required=%0h", name, s, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a termination is presented.
  task automatic mon_step(input int s);
    logic [2:0] r;
    logic [1:0] k;
    rsp_t       e;
    bool_empty: begin end
    r = {ack[s], err[s], rty[s]};
    if (r != 3'b000) begin
      chk("rsp_onehot", s, $countones(r), 1);
      chk("rsp_not_back_to_back", s, 32'(prev_rsp[s]), 0);
      if ((s == 0 && q0.size() == 0) || (s == 1 && q1.size() == 0)) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp dut%0d actual=%b required=none", s, r);
      end else begin
        if (s == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        k = ack[s] ? KAck : (err[s] ? KErr : KRty);
        chk("rsp_kind", s, 32'(k), 32'(e.kind));
        chk("rsp_data", s, 32'(dat_r[s]), 32'(e.data));
      end
    end else begin
      chk("dat_idle_zero", s, 32'(dat_r[s]), 0);
    end
    prev_rsp[s] = r;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_step(0);
      mon_step(1);
    end
  end

  // One Wishbone transfer; called and returns 1 time unit after a rising edge.
  task automatic bus(input int s, input bit w, input logic [DW-1:0] d, input logic [1:0] ek,
                     input logic [DW-1:0] ed, input int el, input bit keep);
    rsp_t e;
    int   n;
    bit   seen;
    int   ws;
    ws     = (s == 0) ? 2 : 3;
    e.kind = ek;
    e.data = ed;
    if (s == 0) q0.push_back(e);
    else        q1.push_back(e);
    cyc[s]   = 1'b1;
    stb[s]   = 1'b1;
    we[s]    = w;
    dat_w[s] = d;
    n        = 0;
    seen     = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (ack[s] | err[s] | rty[s]) seen = 1'b1;
    end
    chk("rsp_latency", s, n, ws + 2);
    if (seen) chk("level_before_update", s, 32'(lvl[s]), 32'(last_lvl[s]));
    @(posedge clk);
    #1;
    if (!keep) begin
      cyc[s] = 1'b0;
      stb[s] = 1'b0;
    end
    chk("level", s, 32'(lvl[s]), el);
    chk("full", s, 32'(full[s]), 32'(el == DEPTH));
    chk("empty", s, 32'(empty[s]), 32'(el == 0));
    last_lvl[s] = LW'(el);
  endtask

  task automatic run_dut(input int s);
    logic [1:0] bad;
    bad = (s == 1) ? KErr : KRty;
    bus(s, 1'b1, 8'hA5, KAck, 8'h00, 1, 1'b0);
    bus(s, 1'b0, 8'h00, KAck, 8'hA5, 0, 1'b0);
    bus(s, 1'b0, 8'h00, bad, 8'h00, 0, 1'b0);
    for (int i = 1; i <= 4; i++) bus(s, 1'b1, 8'(i), KAck, 8'h00, i, 1'b1);
    bus(s, 1'b1, 8'h05, bad, 8'h00, 4, 1'b0);
    for (int i = 1; i <= 4; i++) bus(s, 1'b0, 8'h00, KAck, 8'(i), 4 - i, 1'b0);
    for (int i = 0; i < 10; i++) begin
      bus(s, 1'b1, 8'(i), KAck, 8'h00, 1, 1'b0);
      bus(s, 1'b0, 8'h00, KAck, 8'(i), 0, 1'b0);
    end
    // Abort by dropping cyc one clock into WAIT; stb stays high meanwhile.
    cyc[s]   = 1'b1;
    stb[s]   = 1'b1;
    we[s]    = 1'b1;
    dat_w[s] = 8'h77;
    @(posedge clk);
    @(posedge clk);
    #1 cyc[s] = 1'b0;
    repeat (6) @(posedge clk);
    #1 stb[s] = 1'b0;
    chk("abort_level", s, 32'(lvl[s]), 0);
    // Abort by reset during WAIT with one entry held.
    bus(s, 1'b1, 8'h11, KAck, 8'h00, 1, 1'b0);
    cyc[s]   = 1'b1;
    stb[s]   = 1'b1;
    dat_w[s] = 8'h22;
    @(posedge clk);
    #1;
    rst[s] = 1'b1;
    cyc[s] = 1'b0;
    stb[s] = 1'b0;
    @(posedge clk);
    #1 rst[s] = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("rst_abort_level", s, 32'(lvl[s]), 0);
    chk("rst_abort_empty", s, 32'(empty[s]), 1);
    last_lvl[s] = '0;
    bus(s, 1'b0, 8'h00, bad, 8'h00, 0, 1'b0);
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      rst[s]      = 1'b1;
      cyc[s]      = 1'b0;
      stb[s]      = 1'b0;
      we[s]       = 1'b0;
      dat_w[s]    = '0;
      prev_rsp[s] = '0;
      last_lvl[s] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("reset_ack", s, 32'(ack[s]), 0);
      chk("reset_err", s, 32'(err[s]), 0);
      chk("reset_rty", s, 32'(rty[s]), 0);
      chk("reset_dat", s, 32'(dat_r[s]), 0);
      chk("reset_level", s, 32'(lvl[s]), 0);
      chk("reset_empty", s, 32'(empty[s]), 1);
      chk("reset_full", s, 32'(full[s]), 0);
    end
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    mon_en = 1'b1;
    run_dut(0);
    run_dut(1);
    repeat (4) @(posedge clk);
    chk("scoreboard_drained", 0, q0.size(), 0);
    chk("scoreboard_drained", 1, q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish checks=%0d failures=%0d",
             checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
